// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, arctangent table and state type for the CORDIC engine
//
// Purpose:
//   Fixed-point format constants (Q3.24, 27-bit two's complement), angle
//   constants, the micro-rotation arctangent table and the engine FSM state
//   encoding.
//
// Contents:
//   CORDIC_W, CORDIC_FRAC        word width / fraction bits
//   HALF_PI, PI, CORDIC_GAIN     Q3.24 constants
//   ATAN_TABLE[0..26]            round(atan(2^-i) * 2^24)
//   cordic_state_t               IDLE / RUN / DONE
//   atan_lookup()                range-guarded table read

package cordic_pkg;

    localparam int CORDIC_W     = 27;
    localparam int CORDIC_FRAC  = 24;
    localparam int CORDIC_TBL_N = 27;
    localparam int STAGE_W      = 5;

    localparam logic signed [CORDIC_W-1:0] HALF_PI     = 27'sd26353589;
    localparam logic signed [CORDIC_W-1:0] PI          = 27'sd52707179;
    localparam logic signed [CORDIC_W-1:0] CORDIC_GAIN = 27'sd10188014;

    // Entries from i=9 onward are exact powers of two after rounding because
    // atan(2^-i) differs from 2^-i by less than half an LSB there; the last
    // two entries round to zero.
    localparam logic signed [CORDIC_W-1:0] ATAN_TABLE [0:CORDIC_TBL_N-1] = '{
        27'sd13176795,
        27'sd7778716,
        27'sd4110060,
        27'sd2086331,
        27'sd1047214,
        27'sd524117,
        27'sd262123,
        27'sd131069,
        27'sd65536,
        27'sd32768,
        27'sd16384,
        27'sd8192,
        27'sd4096,
        27'sd2048,
        27'sd1024,
        27'sd512,
        27'sd256,
        27'sd128,
        27'sd64,
        27'sd32,
        27'sd16,
        27'sd8,
        27'sd4,
        27'sd2,
        27'sd1,
        27'sd0,
        27'sd0
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cordic_state_t;

    // A 5-bit index can address past the table end; those slots read as zero.
    function automatic logic signed [CORDIC_W-1:0] atan_lookup(input logic [STAGE_W-1:0] idx);
        logic signed [CORDIC_W-1:0] result;
        result = '0;
        if (int'(idx) < CORDIC_TBL_N) begin
            result = ATAN_TABLE[idx];
        end
        return result;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - combinational single CORDIC micro-rotation (rotation mode)
//
// Purpose:
//   Applies one rotation by +/-atan(2^-i), choosing the direction from the
//   sign of the residual angle so that z is driven toward zero.
//
// Ports:
//   i_x, i_y, i_z   current vector and residual angle (Q3.24, signed)
//   i_atan          atan(2^-i) for this stage (Q3.24)
//   i_stage         stage index i (shift amount)
//   o_x, o_y, o_z   rotated vector and updated residual angle

module cordic_stage
    import cordic_pkg::*;
(
    input  logic signed [CORDIC_W-1:0] i_x,
    input  logic signed [CORDIC_W-1:0] i_y,
    input  logic signed [CORDIC_W-1:0] i_z,
    input  logic signed [CORDIC_W-1:0] i_atan,
    input  logic        [STAGE_W-1:0]  i_stage,
    output logic signed [CORDIC_W-1:0] o_x,
    output logic signed [CORDIC_W-1:0] o_y,
    output logic signed [CORDIC_W-1:0] o_z
);

    logic signed [CORDIC_W-1:0] w_x_sh;
    logic signed [CORDIC_W-1:0] w_y_sh;
    logic                       w_z_pos;

    // Arithmetic shift floors toward -inf; the resulting bias is part of the
    // accuracy budget rather than corrected here.
    assign w_x_sh  = i_x >>> i_stage;
    assign w_y_sh  = i_y >>> i_stage;
    assign w_z_pos = ~i_z[CORDIC_W-1];

    // Sums wrap on overflow; in-contract operands never reach the wrap.
    assign o_x = w_z_pos ? (i_x - w_y_sh) : (i_x + w_y_sh);
    assign o_y = w_z_pos ? (i_y + w_x_sh) : (i_y - w_x_sh);
    assign o_z = w_z_pos ? (i_z - i_atan) : (i_z + i_atan);

endmodule

// File: rtl/cordic_iter_engine.sv
// rtl/cordic_iter_engine.sv - iterative rotation-mode CORDIC engine around one cordic_stage
//
// Purpose:
//   Accepts one (x, y, z) operand set, folds the angle into +/-pi/2 with a
//   quadrant pre-rotation, then reuses a single cordic_stage once per clock
//   for N_ITER micro-rotations and holds the result until it is taken.
//
// Parameters:
//   N_ITER      number of micro-rotations, 1..26
//
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   in_valid / in_ready     operand handshake (ready only in IDLE)
//   in_x, in_y, in_z        Q3.24 operands, z in -pi..+pi
//   out_valid / out_ready   result handshake (valid only in DONE)
//   out_x, out_y, out_z     Q3.24 result; zero whenever out_valid is low
//   busy                    high in RUN or DONE

module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int N_ITER = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [CORDIC_W-1:0] in_x,
    input  logic signed [CORDIC_W-1:0] in_y,
    input  logic signed [CORDIC_W-1:0] in_z,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [CORDIC_W-1:0] out_x,
    output logic signed [CORDIC_W-1:0] out_y,
    output logic signed [CORDIC_W-1:0] out_z,
    output logic                       busy
);

    localparam logic [STAGE_W-1:0]         LAST_STAGE  = STAGE_W'(N_ITER - 1);
    localparam logic signed [CORDIC_W-1:0] NEG_HALF_PI = -HALF_PI;

    cordic_state_t r_state;
    cordic_state_t w_state_nxt;

    logic signed [CORDIC_W-1:0] r_x;
    logic signed [CORDIC_W-1:0] r_y;
    logic signed [CORDIC_W-1:0] r_z;
    logic        [STAGE_W-1:0]  r_cnt;

    logic                       w_load;
    logic                       w_step;
    logic                       w_done;
    logic signed [CORDIC_W-1:0] w_pre_x;
    logic signed [CORDIC_W-1:0] w_pre_y;
    logic signed [CORDIC_W-1:0] w_pre_z;
    logic signed [CORDIC_W-1:0] w_atan;
    logic signed [CORDIC_W-1:0] w_stg_x;
    logic signed [CORDIC_W-1:0] w_stg_y;
    logic signed [CORDIC_W-1:0] w_stg_z;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_cnt == LAST_STAGE) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Quadrant pre-rotation: a +/-90 degree swap brings |z| within pi/2,
    // inside the ~1.74 rad convergence range of the micro-rotations.
    // Exactly +/-HALF_PI is left alone since it already converges.
    // ------------------------------------------------------------------
    always_comb begin
        w_pre_x = in_x;
        w_pre_y = in_y;
        w_pre_z = in_z;
        if (in_z > HALF_PI) begin
            w_pre_x = -in_y;
            w_pre_y = in_x;
            w_pre_z = in_z - HALF_PI;
        end else if (in_z < NEG_HALF_PI) begin
            w_pre_x = in_y;
            w_pre_y = -in_x;
            w_pre_z = in_z + HALF_PI;
        end
    end

    // ------------------------------------------------------------------
    // Shared micro-rotation datapath
    // ------------------------------------------------------------------
    assign w_atan = atan_lookup(r_cnt);

    cordic_stage u_stage (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_atan  (w_atan),
        .i_stage (r_cnt),
        .o_x     (w_stg_x),
        .o_y     (w_stg_y),
        .o_z     (w_stg_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_x   <= w_pre_x;
            r_y   <= w_pre_y;
            r_z   <= w_pre_z;
            r_cnt <= '0;
        end else if (w_step) begin
            r_x   <= w_stg_x;
            r_y   <= w_stg_y;
            r_z   <= w_stg_z;
            r_cnt <= r_cnt + STAGE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result port: intermediate iterations are never visible.
    // ------------------------------------------------------------------
    assign w_done = (r_state == ST_DONE);
    assign out_x  = w_done ? r_x : '0;
    assign out_y  = w_done ? r_y : '0;
    assign out_z  = w_done ? r_z : '0;

endmodule
